// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous RAM port between instruction fetch and the data stage.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              sysclk,
    input  logic              cpu_reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall_if,
    input  logic              halt,
    output logic              halted
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       rd_pend_q, rd_pend_d, rd_owner_q, rd_owner_d;
    logic       run, if_win, rd_gnt;
    always_comb begin
        run        = (state_q == RUN) & ~cpu_reset;
        if_win     = if_req & (~dm_req | (starve_q == 4'(STARVE_MAX)));
        if_gnt     = run & if_win;
        dm_gnt     = run & dm_req & ~if_win;
        stall_if   = if_req & ~if_gnt & ~cpu_reset;
        ram_en     = if_gnt | dm_gnt;
        ram_we     = dm_gnt & dm_we;
        ram_addr   = if_gnt ? if_addr : dm_gnt ? dm_addr : '0;
        ram_wdata  = ram_en ? dm_wdata : '0;
        rd_gnt     = if_gnt | (dm_gnt & ~dm_we);
        rd_pend_d  = rd_gnt;
        rd_owner_d = rd_gnt ? dm_gnt : rd_owner_q;
        starve_d   = (if_gnt | ~if_req) ? 4'd0 :
                     (dm_gnt && starve_q < 4'(STARVE_MAX)) ? starve_q + 4'd1 : starve_q;
        // DRAIN never grants, so it leaves as soon as the last read has returned
        state_d    = (state_q == RUN && halt) ? DRAIN :
                     (state_q == DRAIN && !rd_pend_d) ? HALTED : state_q;
        if_rvalid  = rd_pend_q & ~rd_owner_q & ~cpu_reset;
        dm_rvalid  = rd_pend_q & rd_owner_q & ~cpu_reset;
        if_rdata   = if_rvalid ? ram_rdata : '0;
        dm_rdata   = dm_rvalid ? ram_rdata : '0;
        halted     = (state_q == HALTED) & ~cpu_reset;
    end
    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            state_q    <= RUN;
            starve_q   <= 4'd0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector checks of mem_port_arbiter against a behavioural RAM.
module tb_mem_port_arbiter;
    typedef struct {
        logic        rst, ir, dr, dw, h;
        logic [9:0]  ia, da;
        logic [31:0] dwd;
        logic        e_ig, e_dg, e_st, e_en, e_we, e_irv, e_drv, e_halt;
        logic [9:0]  e_addr;
        logic [31:0] e_ird, e_drd;
    } vec_t;

    logic        sysclk = 1'b0;
    logic        cpu_reset, if_req, dm_req, dm_we, halt;
    logic [9:0]  if_addr, dm_addr, ram_addr;
    logic [31:0] dm_wdata, if_rdata, dm_rdata, ram_wdata, ram_rdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, ram_en, ram_we, stall_if, halted;
    logic [31:0] mem [1024];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        else if (ram_en) ram_rdata <= mem[ram_addr];
    end

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(4)) dut (
        .sysclk(sysclk), .cpu_reset(cpu_reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stall_if(stall_if), .halt(halt), .halted(halted)
    );

    function automatic vec_t mk(input logic rst, ir, input int ia, input logic dr, dw, input int da,
                                input logic [31:0] dwd, input logic h,
                                input logic e_ig, e_dg, e_st, e_en, e_we, input int e_addr,
                                input logic e_irv, input logic [31:0] e_ird,
                                input logic e_drv, input logic [31:0] e_drd, input logic e_halt);
        vec_t v;
        v.rst = rst; v.ir = ir; v.ia = 10'(ia); v.dr = dr; v.dw = dw; v.da = 10'(da); v.dwd = dwd; v.h = h;
        v.e_ig = e_ig; v.e_dg = e_dg; v.e_st = e_st; v.e_en = e_en; v.e_we = e_we; v.e_addr = 10'(e_addr);
        v.e_irv = e_irv; v.e_ird = e_ird; v.e_drv = e_drv; v.e_drd = e_drd; v.e_halt = e_halt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge sysclk);
        cpu_reset = v.rst; if_req = v.ir; if_addr = v.ia; dm_req = v.dr; dm_we = v.dw;
        dm_addr = v.da; dm_wdata = v.dwd; halt = v.h;
        #1;
        chk({tag, ".if_gnt"}, 32'(if_gnt), 32'(v.e_ig));
        chk({tag, ".dm_gnt"}, 32'(dm_gnt), 32'(v.e_dg));
        chk({tag, ".stall_if"}, 32'(stall_if), 32'(v.e_st));
        chk({tag, ".ram_en"}, 32'(ram_en), 32'(v.e_en));
        chk({tag, ".ram_we"}, 32'(ram_we), 32'(v.e_we));
        chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(v.e_addr));
        chk({tag, ".ram_wdata"}, ram_wdata, v.e_en ? v.dwd : 32'd0);
        chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(v.e_irv));
        chk({tag, ".if_rdata"}, if_rdata, v.e_ird);
        chk({tag, ".dm_rvalid"}, 32'(dm_rvalid), 32'(v.e_drv));
        chk({tag, ".dm_rdata"}, dm_rdata, v.e_drd);
        chk({tag, ".halted"}, 32'(halted), 32'(v.e_halt));
    endtask

    initial begin
        vec_t tbl [14];
        logic prev_if;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i) + 32'h100;
        ram_rdata = '0;
        tbl[0]  = mk(1, 1, 5, 1, 0, 9, 0, 0,                   0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0,                   1, 0, 0, 1, 0, 0,      0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 0, 0, 0, 0,                   1, 0, 0, 1, 0, 1,      1, 'h100, 0, 0, 0);
        tbl[4]  = mk(0, 1, 2, 0, 0, 0, 0, 0,                   1, 0, 0, 1, 0, 2,      1, 'h101, 0, 0, 0);
        tbl[5]  = mk(0, 1, 3, 0, 0, 0, 0, 0,                   1, 0, 0, 1, 0, 3,      1, 'h102, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0,      1, 'h103, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 1, 'h3FF, 32'hDEADBEEF, 0,    0, 1, 0, 1, 1, 'h3FF,  0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 'h10, 1, 0, 'h20, 0, 0,             0, 1, 1, 1, 0, 'h20,   0, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 'h10, 0, 0, 0, 0, 0,                1, 0, 0, 1, 0, 'h10,   0, 0, 1, 'h120, 0);
        tbl[11] = mk(0, 0, 0, 1, 0, 'h3FF, 0, 0,               0, 1, 0, 1, 0, 'h3FF,  1, 'h110, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0,      0, 0, 1, 32'hDEADBEEF, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // both ports request for 10 cycles: IF must break through every fifth cycle
        prev_if = 1'b0;
        for (int c = 0; c < 10; c++) begin
            logic ig;
            ig = (c == 4 || c == 9);
            apply(mk(0, 1, 'h40, 1, 0, 'h30, 0, 0, ig, !ig, !ig, 1, 0, ig ? 'h40 : 'h30,
                     c > 0 && prev_if, (c > 0 && prev_if) ? 32'h140 : 32'h0,
                     c > 0 && !prev_if, (c > 0 && !prev_if) ? 32'h130 : 32'h0, 0),
                  $sformatf("starve%0d", c));
            prev_if = ig;
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h140, 0, 0, 0), "starve_tail");

        // halt raised with a load granted the same cycle
        apply(mk(0, 0, 0, 1, 0, 'h20, 0, 1, 0, 1, 0, 1, 0, 'h20, 0, 0, 0, 0, 0), "halt_a");
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h120, 0), "halt_b");
        for (int c = 0; c < 4; c++)
            apply(mk(0, 1, 0, 1, 0, 'h20, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), $sformatf("halted%0d", c));

        // reset recovers from HALTED, then drops a fetch that is in flight
        apply(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_a");
        apply(mk(0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0), "rst_b");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_c");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_d");
        apply(mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0), "rst_e");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h103, 0, 0, 0), "rst_f");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous instruction/data RAM between the pipeline's fetch stage (IF) and its memory stage (DM).
- Sits between the processor pipeline and the RAM macro.
- Drives the IF stall that the hazard logic consumes.
- Stops granting cleanly when the processor decodes the halt opcode (op all ones), so the bench can end the run deterministically.

Parameters:
ADDR_W, 10, word address width of RAM
DATA_W, 32, RAM data width
STARVE_MAX, 4, max consecutive cycles DM may win while IF is waiting; legal 1..15

Ports:
sysclk  in  1  system clock, all logic on rising edge
cpu_reset  in  1  synchronous reset, active-high
if_req  in  1  fetch request, held until granted
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch granted this cycle (combinational)
if_rvalid  out  1  fetch data valid (one cycle after grant)
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data-stage request, held until granted
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data word address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  data access granted this cycle (combinational)
dm_rvalid  out  1  load data valid (one cycle after load grant)
dm_rdata  out  DATA_W  load data
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en & ~ram_we
stall_if  out  1  if_req & ~if_gnt
halt  in  1  halt opcode decoded (level)
halted  out  1  arbiter idle and stopped

Behaviour:
- Single clock sysclk. cpu_reset is synchronous and active-high.
- Reset effects:
  - state = RUN; starve_cnt = 0; rd_owner/rd_pend cleared.
  - if_rvalid, dm_rvalid and halted all 0.
  - Combinational outputs are 0 while cpu_reset is high.
  - A read in flight at reset is dropped; no rvalid follows.
- States:
  - RUN: grants allowed.
  - DRAIN: no new grants; waits for the outstanding read.
  - HALTED: halted = 1; no grants.
- Transitions:
  - RUN -> DRAIN when halt = 1 is sampled. Grants are still issued in that same cycle.
  - DRAIN -> HALTED when rd_pend = 0.
  - HALTED exits only via cpu_reset.
  - halt deasserting in DRAIN or HALTED has no effect.
- Arbitration in RUN, evaluated combinationally each cycle:
  - Only one requester: it is granted.
  - Both requesting: DM wins unless starve_cnt == STARVE_MAX, in which case IF wins.
  - Exactly one of if_gnt and dm_gnt may be high in a cycle.
- starve_cnt (4-bit), registered:
  - Increments when dm_gnt & if_req.
  - Clears to 0 when if_gnt is high, or when if_req = 0.
  - Saturates at STARVE_MAX.
- RAM mux:
  - ram_en = if_gnt | dm_gnt.
  - ram_we = dm_gnt & dm_we.
  - ram_addr = granted requester's address.
  - ram_wdata = dm_wdata.
  - When idle, ram_addr/ram_wdata are 0.
- Read return:
  - On any read grant, register rd_pend = 1 and rd_owner (0 = IF, 1 = DM).
  - Next cycle, the owner's rvalid = 1 and its rdata = ram_rdata.
  - The non-owner's rdata is 0.
  - Stores produce no rvalid.
- Back-to-back grants every cycle are legal: latency 1, throughput 1 access/cycle.
- rd_pend clears the cycle after the grant unless a new read is granted that cycle.
- stall_if = if_req & ~if_gnt. This is also high in DRAIN/HALTED while if_req = 1.
- Requests must hold stable until granted. Changing the address before the grant is the requester's error; the arbiter does not check it.
- halted is registered; it rises the cycle after DRAIN sees rd_pend = 0.

Test Plan:
- IF only, if_addr = 0x000..0x003 consecutive -> if_gnt high 4 cycles, if_rvalid high 4 cycles starting 1 cycle later. With RAM preloaded to addr+0x100, if_rdata = 0x100..0x103.
- Conflict: if_req = 1 and dm_req = 1 (load, addr 0x20) for 1 cycle -> dm_gnt = 1, if_gnt = 0, stall_if = 1. Next cycle dm_rvalid = 1, dm_rdata = mem[0x20], and IF is granted.
- Starvation: STARVE_MAX = 4, dm_req held 10 cycles, if_req held -> DM granted cycles 0-3, IF cycle 4, DM cycles 5-8, IF cycle 9.
- Store: dm_we = 1, addr 0x3FF, wdata 0xDEADBEEF -> ram_we = 1 for exactly 1 cycle, no dm_rvalid. A subsequent load of 0x3FF returns 0xDEADBEEF.
- Halt: load granted in the same cycle halt rises -> dm_rvalid the next cycle, halted = 1 one cycle after that. if_req thereafter yields if_gnt = 0 and stall_if = 1 indefinitely.
- Reset mid-read: cpu_reset = 1 in the cycle after a fetch grant -> if_rvalid = 0. All outputs are 0 while reset is high; normal grants resume the first cycle after reset falls.
